// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared state encodings and ALU opcodes for the UART/ALU sequencer
package uart_alu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-byte watchdog; saturating counter that flags expiry at TIMEOUT_CYCLES-1
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int NB_TIMER = $clog2(TIMEOUT_CYCLES);
    localparam logic [NB_TIMER-1:0] LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMER-1:0] count;

    // Saturate at LAST: the owning FSM always leaves the timed states before a wrap matters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && (count != LAST)) begin
            count <= count + NB_TIMER'(1);
        end
    end

    assign o_expire = i_enable && (count == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A/B/opcode frame from UART rx, runs the ALU, offers the result to tx
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t state;
    state_t state_next;

    logic timer_enable;
    logic timer_clear;
    logic timer_expire;
    logic timeout_fire;

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (timer_clear),
        .i_enable(timer_enable),
        .o_expire(timer_expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_enable = 1'b0;
        timer_clear  = 1'b1;
        timeout_fire = 1'b0;
        o_tx_valid   = 1'b0;
        o_busy       = 1'b0;
        case (state)
            ST_WAIT_A: begin
                if (i_rx_valid) state_next = ST_WAIT_B;
            end
            ST_WAIT_B, ST_WAIT_OP: begin
                timer_enable = 1'b1;
                timer_clear  = i_rx_valid;
                // A byte landing on the expiry cycle wins over the timeout.
                timeout_fire = timer_expire && !i_rx_valid;
                if (i_rx_valid) begin
                    state_next = (state == ST_WAIT_B) ? ST_WAIT_OP : ST_EXEC;
                end else if (timer_expire) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                o_busy     = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                o_busy     = 1'b1;
                o_tx_valid = 1'b1;
                if (i_tx_ready) state_next = ST_WAIT_A;
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_timeout <= timeout_fire;
            o_overrun <= i_rx_valid && o_busy;
            if (i_rx_valid && (state == ST_WAIT_A)) o_alu_a <= i_rx_data;
            if (i_rx_valid && (state == ST_WAIT_B)) o_alu_b <= i_rx_data;
            if (i_rx_valid && (state == ST_WAIT_OP)) o_alu_op <= i_rx_data[NB_OP-1:0];
            if (state == ST_EXEC) o_tx_data <= i_alu_result;
        end
    end

    generate
        if (NB_DATA > NB_OP) begin : g_unused_op_bits
            logic unused_rx_high_bits;
            assign unused_rx_high_bits = ^i_rx_data[NB_DATA-1:NB_OP];
        end
    endgenerate

endmodule
